// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// datapath mux selects and the immediate-format decoder.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'h0,
        S_DECODE   = 4'h1,
        S_MEMADR   = 4'h2,
        S_MEMREAD  = 4'h3,
        S_MEMWB    = 4'h4,
        S_MEMWRITE = 4'h5,
        S_EXECR    = 4'h6,
        S_EXECI    = 4'h7,
        S_ALUWB    = 4'h8,
        S_BRANCH   = 4'h9,
        S_JAL      = 4'hA,
        S_JALR     = 4'hB,
        S_JALR2    = 4'hC,
        S_LUI      = 4'hD,
        S_AUIPC    = 4'hE,
        S_TRAP     = 4'hF
    } state_t;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_CMP    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Unknown opcodes fall back to I-format; they trap in DECODE anyway.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch-taken evaluation from funct3 and the ALU comparison flags.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       bad_funct3
);

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute on
// the shared datapath, waits on mem_ready, and traps on bad encodings or timeouts.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_dbg
);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg;
    logic       illegal_reg, bus_error_reg;
    logic       taken, bad_funct3;
    logic       in_wait, timeout, decode_bad;

    branch_cond u_branch_cond (
        .funct3     (funct3),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .taken      (taken),
        .bad_funct3 (bad_funct3)
    );

    assign in_wait = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                     (state_reg == S_MEMWRITE);
    assign timeout = (WAIT_LIMIT != 0) && in_wait && !mem_ready &&
                     (wait_cnt_reg == 8'(WAIT_LIMIT - 1));

    always_comb begin
        decode_bad = 1'b0;
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
                        else if (timeout) state_next = S_TRAP;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default: begin
                        state_next = S_TRAP;
                        decode_bad = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
                        else if (timeout) state_next = S_TRAP;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
                        else if (timeout) state_next = S_TRAP;
            S_EXECR, S_EXECI, S_JAL, S_JALR2, S_LUI, S_AUIPC:
                        state_next = (state_reg == S_EXECR || state_reg == S_EXECI ||
                                      state_reg == S_JAL || state_reg == S_JALR2 ||
                                      state_reg == S_LUI || state_reg == S_AUIPC)
                                     ? S_ALUWB : S_FETCH;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = bad_funct3 ? S_TRAP : S_FETCH;
            S_JALR:     state_next = S_JALR2;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // The wait counter only advances while parked in a memory state; any move resets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_FETCH;
            wait_cnt_reg  <= 8'd0;
            illegal_reg   <= 1'b0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                wait_cnt_reg <= 8'd0;
            else if (in_wait && !mem_ready && wait_cnt_reg != 8'hFF)
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            if (decode_bad || (state_reg == S_BRANCH && bad_funct3))
                illegal_reg <= 1'b1;
            if (timeout)
                bus_error_reg <= 1'b1;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        case (state_reg)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                pc_write   = mem_ready;
                ir_write   = mem_ready;
            end
            S_DECODE:   begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
            S_MEMADR:   begin alu_src_a = SRCA_RS1;   alu_src_b = SRCB_IMM; end
            S_MEMREAD:  begin adr_src = 1'b1; mem_read = 1'b1; end
            S_MEMWB:    begin result_src = RES_MEM; reg_write = 1'b1; end
            S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
            S_EXECR:    begin alu_src_a = SRCA_RS1; alu_op = ALU_FUNCT; end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_CMP;
                pc_write  = taken & ~bad_funct3;
            end
            S_JAL, S_JALR2: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_JALR:     begin alu_src_a = SRCA_RS1;   alu_src_b = SRCB_IMM; end
            S_LUI:      begin alu_src_a = SRCA_ZERO;  alu_src_b = SRCB_IMM; end
            S_AUIPC:    begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
            default: ;
        endcase
        // No architectural side effect may escape during a reset cycle.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign imm_src       = imm_src_of(opcode);
    assign illegal_instr = illegal_reg;
    assign bus_error     = bus_error_reg;
    assign state_dbg     = state_reg;

endmodule
